// File: rtl/sys_mem_pkg.sv
// Shared types and constants for the system memory model.
package sys_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_state_t;

    localparam int MEM_BYTES      = 16384;
    localparam int DATA_W         = 16;
    localparam int BYTE_W         = 8;
    localparam int ADDR_W_DEF     = $clog2(MEM_BYTES);
    localparam int ACCESS_LAT_DEF = 3;
    localparam int CNT_W          = 4;

endpackage

// File: rtl/sys_mem_model_if.sv
// Request/response handshake between the memory interface unit and the memory model.
interface sys_mem_model_if #(
    parameter int ADDR_W = 14
);
    logic              read_req;
    logic              write_req;
    logic [ADDR_W-1:0] addrout;
    logic              mem_resp;

    modport master (output read_req, output write_req, output addrout, input mem_resp);
    modport slave  (input read_req, input write_req, input addrout, output mem_resp);
endinterface

// File: rtl/mem_byte_array.sv
// Byte storage: one synchronous little-endian 16-bit write port, one combinational byte read port.
module mem_byte_array
    import sys_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] waddr_hi;

    // The upper byte lands at addr+1, wrapping from the top of the array to 0.
    assign waddr_hi = waddr + ADDR_W'(1);

    // NOTE: the storage array has no reset; contents survive reset and only the control path is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr]    <= wdata[BYTE_W-1:0];
            mem[waddr_hi] <= wdata[DATA_W-1:BYTE_W];
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sys_mem_model.sv
// System memory model: one access at a time, fixed latency, one-cycle mem_resp pulse.
// Optional protocol checker enabled by defining SYS_MEM_PROT_CHK_EN (adds prot_err output).
module sys_mem_model
    import sys_mem_pkg::*;
#(
    parameter int ACCESS_LAT = ACCESS_LAT_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sys_mem_model_if.slave        bus,
    inout  wire  [DATA_W-1:0]     datatofrommem
`ifdef SYS_MEM_PROT_CHK_EN
    ,
    output logic                  prot_err
`endif
);

    mem_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              op_write_q;
    logic              rd_drive_q;
    logic              commit;
    logic [BYTE_W-1:0] rdata;

    // Gated by reset_n so a reset on the final BUSY edge aborts the write.
    assign commit = reset_n && (state == BUSY) && (cnt == '0) && op_write_q;

    mem_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (commit),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (addr_q),
        .rdata (rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            bus.mem_resp <= 1'b0;
            cnt          <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_write_q   <= 1'b0;
            rd_drive_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.mem_resp <= 1'b0;
                    rd_drive_q   <= 1'b0;
                    if (bus.write_req || bus.read_req) begin
                        addr_q     <= bus.addrout;
                        op_write_q <= bus.write_req;
                        if (bus.write_req) wdata_q <= datatofrommem;
                        cnt        <= CNT_W'(ACCESS_LAT - 1);
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state        <= RESP;
                        bus.mem_resp <= 1'b1;
                        rd_drive_q   <= !op_write_q;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    bus.mem_resp <= 1'b0;
                    rd_drive_q   <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.mem_resp <= 1'b0;
                    rd_drive_q   <= 1'b0;
                end
            endcase
        end
    end

    // Bus is driven only in the response cycle of a read.
    assign datatofrommem = rd_drive_q ? {{(DATA_W-BYTE_W){1'b0}}, rdata} : {DATA_W{1'bz}};

`ifdef SYS_MEM_PROT_CHK_EN
    logic viol;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        viol = 1'b0;
        case (state)
            IDLE:    viol = bus.read_req && bus.write_req;
            BUSY:    viol = op_write_q ? !bus.write_req : !bus.read_req;
            RESP:    viol = bus.read_req || bus.write_req;
            default: viol = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)  prot_err <= 1'b0;
        else if (viol) prot_err <= 1'b1;
    end

    a_both_req: assert property (@(posedge clk) disable iff (!reset_n)
        !(state == IDLE && bus.read_req && bus.write_req));
    a_req_drop: assert property (@(posedge clk) disable iff (!reset_n)
        !(state == BUSY && (op_write_q ? !bus.write_req : !bus.read_req)));
    a_resp_req: assert property (@(posedge clk) disable iff (!reset_n)
        !(state == RESP && (bus.read_req || bus.write_req)));
`endif

endmodule
